// File: rtl/npc_unit_pkg.sv
// rtl/npc_unit_pkg.sv - next-PC operation codes, branch codes and FSM state encoding
package npc_unit_pkg;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_JMP  = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [2:0] BR_EQ = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_LT = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_NO = 3'd4;

  typedef enum logic [1:0] {
    NPC_ST_BOOT = 2'd0,
    NPC_ST_RUN  = 2'd1,
    NPC_ST_HALT = 2'd2
  } npc_state_e;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/npc_unit_br_cmp.sv
// rtl/npc_unit_br_cmp.sv - branch condition evaluation from ALU flags
module npc_unit_br_cmp
  import npc_unit_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_LT:   taken = lt;
      BR_GE:   taken = ~lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// rtl/npc_unit.sv - fetch PC owner: EX-stage redirect, flush, stall and misalign halt
// Optional perf counters enabled by defining NPC_PERF_EN.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [1:0]       ex_npc_op,
  input  logic [2:0]       ex_br_op,
  input  logic             ex_alu_zero,
  input  logic             ex_alu_lt,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_alu_c,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] taken_br_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  npc_state_e  state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] target;
  logic        taken, is_jmp, is_jal, is_jalr, redirect, aligned;

  npc_unit_br_cmp u_br_cmp (
    .br_op (ex_br_op),
    .zero  (ex_alu_zero),
    .lt    (ex_alu_lt),
    .taken (taken)
  );

  // ex_valid gates every decode term so X on a bubble's fields cannot reach redirect
  always_comb begin
    is_jmp   = ex_valid && (ex_npc_op == NPC_JMP);
    is_jal   = ex_valid && (ex_npc_op == NPC_JAL);
    is_jalr  = ex_valid && (ex_npc_op == NPC_JALR);
    target   = is_jalr ? (ex_alu_c & ~32'h1) : (ex_pc + ex_imm);
    redirect = (state == NPC_ST_RUN) && (is_jal || is_jalr || (is_jmp && taken));
    aligned  = is_aligned(target);
    flush    = redirect && aligned;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      NPC_ST_BOOT: state_nxt = NPC_ST_RUN;
      NPC_ST_RUN: begin
        if (redirect && !aligned) state_nxt = NPC_ST_HALT;
        else if (flush)           pc_nxt    = target;
        else if (!stall)          pc_nxt    = pc + 32'd4;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NPC_ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  assign pc4         = pc + 32'd4;
  assign fetch_valid = (state == NPC_ST_RUN) && !stall;
  assign halted      = (state == NPC_ST_HALT);

`ifdef NPC_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      taken_br_cnt <= '0;
      stall_cnt    <= '0;
    end else if (state == NPC_ST_RUN) begin
      if (flush)             redirect_cnt <= redirect_cnt + CNT_ONE;
      if (flush && is_jmp)   taken_br_cnt <= taken_br_cnt + CNT_ONE;
      if (stall && !redirect) stall_cnt   <= stall_cnt + CNT_ONE;
    end
  end
`else
  assign redirect_cnt = '0;
  assign taken_br_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_npc_unit.sv
// tb/tb_npc_unit.sv - scoreboard bench for npc_unit (perf checks follow NPC_PERF_EN)
module tb_npc_unit;
  import npc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_npc_op = NPC_PC4;
  logic [2:0]  ex_br_op = BR_NO;
  logic        ex_alu_zero = 1'b0;
  logic        ex_alu_lt = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic [31:0] ex_imm = 32'h0;
  logic [31:0] ex_alu_c = 32'h0;
  logic [31:0] pc, pc4;
  logic        fetch_valid, flush, halted;
  logic [31:0] redirect_cnt, taken_br_cnt, stall_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          passed = 0;
  int          total = 0;
  logic [31:0] model_pc;

  npc_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_npc_op(ex_npc_op), .ex_br_op(ex_br_op), .ex_alu_zero(ex_alu_zero),
    .ex_alu_lt(ex_alu_lt), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_c(ex_alu_c),
    .pc(pc), .pc4(pc4), .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .redirect_cnt(redirect_cnt), .taken_br_cnt(taken_br_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b0 || halted !== 1'b0)
      $display("FAIL reset_state: pc=%h fv=%b flush=%b halted=%b expected 0/0/0/0", pc, fetch_valid, flush, halted);
    else passed++;
    total++;
    if (redirect_cnt !== 0 || taken_br_cnt !== 0 || stall_cnt !== 0)
      $display("FAIL reset_cnt: %0d %0d %0d expected 0 0 0", redirect_cnt, taken_br_cnt, stall_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0)
      $display("FAIL boot_cycle: pc=%h fv=%b expected 00000000/0", pc, fetch_valid);
    else passed++;
    sb.push_back('{32'h0, 1'b1});
    sb.push_back('{32'h4, 1'b1});
    sb.push_back('{32'h8, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || fetch_valid !== e.fv || pc4 !== e.pc + 32'd4)
        $display("FAIL run_seq%0d: pc=%h fv=%b pc4=%h expected pc=%h fv=%b", i, pc, fetch_valid, pc4, e.pc, e.fv);
      else passed++;
      model_pc = e.pc;
    end
  endtask

  task automatic test_jal;
    ex_valid = 1'b1; ex_npc_op = NPC_JAL; ex_pc = 32'h10; ex_imm = 32'h20;
    #1;
    total++;
    if (flush !== 1'b1) $display("FAIL jal_flush: flush=%b expected 1", flush);
    else passed++;
    sb.push_back('{32'h30, 1'b1});
    tick();
    ex_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL jal_target: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    model_pc = e.pc;
  endtask

  task automatic test_beq_stall;
    stall = 1'b1; ex_valid = 1'b1; ex_npc_op = NPC_JMP; ex_br_op = BR_EQ;
    ex_alu_zero = 1'b1; ex_pc = 32'h40; ex_imm = 32'hFFFF_FFF8;
    #1;
    total++;
    if (flush !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL beq_stall_flush: flush=%b fv=%b expected 1/0", flush, fetch_valid);
    else passed++;
    sb.push_back('{32'h38, 1'b0});
    tick();
    ex_alu_zero = 1'b0;
    #1;
    total++;
    if (flush !== 1'b0) $display("FAIL beq_nt_flush: flush=%b expected 0", flush);
    else passed++;
    sb.push_back('{32'h38, 1'b0});
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL beq_redirect: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL beq_hold: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    stall = 1'b0; ex_valid = 1'b0;
    model_pc = e.pc;
  endtask

  task automatic test_masked;
    ex_valid = 1'b0; ex_npc_op = NPC_JAL; ex_br_op = 3'bxxx;
    ex_pc = 'x; ex_imm = 'x; ex_alu_c = 'x; ex_alu_zero = 1'bx; ex_alu_lt = 1'bx;
    #1;
    total++;
    if (flush !== 1'b0) $display("FAIL masked_flush: flush=%b expected 0", flush);
    else passed++;
    sb.push_back('{model_pc + 32'd4, 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL masked_pc: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    model_pc = e.pc;
    ex_alu_zero = 1'b0; ex_alu_lt = 1'b0; ex_alu_c = 32'h0;
  endtask

  task automatic test_branches;
    logic [2:0] ops[7];
    logic       zs[7];
    logic       lts[7];
    logic       tk[7];
    ops = '{BR_NE, BR_NE, BR_LT, BR_LT, BR_GE, BR_GE, BR_NO};
    zs  = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    lts = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    tk  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 7; i++) begin
      ex_valid = 1'b1; ex_npc_op = NPC_JMP; ex_br_op = ops[i];
      ex_alu_zero = zs[i]; ex_alu_lt = lts[i]; ex_pc = model_pc; ex_imm = 32'h40;
      #1;
      total++;
      if (flush !== tk[i]) $display("FAIL br%0d_flush: flush=%b expected %b", i, flush, tk[i]);
      else passed++;
      sb.push_back('{tk[i] ? model_pc + 32'h40 : model_pc + 32'd4, 1'b1});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || fetch_valid !== e.fv)
        $display("FAIL br%0d_pc: pc=%h fv=%b expected pc=%h fv=%b", i, pc, fetch_valid, e.pc, e.fv);
      else passed++;
      model_pc = e.pc;
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_wrap;
    ex_valid = 1'b1; ex_npc_op = NPC_JAL; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h0C;
    sb.push_back('{32'hFFFF_FFFC, 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || pc4 !== 32'h0)
      $display("FAIL wrap_pc4: pc=%h pc4=%h expected pc=%h pc4=00000000", pc, pc4, e.pc);
    else passed++;
    ex_imm = 32'h10;
    sb.push_back('{32'h0, 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc) $display("FAIL wrap_target: pc=%h expected %h", pc, e.pc);
    else passed++;
    ex_valid = 1'b0;
    model_pc = e.pc;
  endtask

  task automatic test_async_reset;
    sb.push_back('{model_pc + 32'd4, 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc) $display("FAIL pre_reset_pc: pc=%h expected %h", pc, e.pc);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0)
      $display("FAIL async_reset: pc=%h fv=%b expected 00000000/0", pc, fetch_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b1; ex_npc_op = NPC_JAL; ex_pc = 32'h80; ex_imm = 32'h80;
    #1;
    total++;
    if (flush !== 1'b0 || fetch_valid !== 1'b0)
      $display("FAIL boot_ignore: flush=%b fv=%b expected 0/0", flush, fetch_valid);
    else passed++;
    sb.push_back('{32'h0, 1'b1});
    tick();
    ex_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL boot_exit: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    model_pc = e.pc;
  endtask

  task automatic test_perf;
    int exp_r, exp_t, exp_s;
    ex_valid = 1'b1; ex_npc_op = NPC_JMP; ex_br_op = BR_NE; ex_alu_zero = 1'b0;
    ex_pc = 32'h200; ex_imm = 32'h10;
    for (int i = 0; i < 3; i++) tick();
    ex_npc_op = NPC_JAL;
    tick();
    ex_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back('{32'h210, 1'b0});
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || fetch_valid !== e.fv)
        $display("FAIL perf_stall%0d: pc=%h fv=%b expected pc=%h fv=%b", i, pc, fetch_valid, e.pc, e.fv);
      else passed++;
    end
    stall = 1'b0;
`ifdef NPC_PERF_EN
    exp_r = 4; exp_t = 3; exp_s = 5;
`else
    exp_r = 0; exp_t = 0; exp_s = 0;
`endif
    total++;
    if (redirect_cnt !== exp_r || taken_br_cnt !== exp_t || stall_cnt !== exp_s)
      $display("FAIL perf_cnt: redirect=%0d taken=%0d stall=%0d expected %0d %0d %0d",
               redirect_cnt, taken_br_cnt, stall_cnt, exp_r, exp_t, exp_s);
    else passed++;
    model_pc = 32'h210;
  endtask

  task automatic test_jalr_halt;
    ex_valid = 1'b1; ex_npc_op = NPC_JALR; ex_alu_c = 32'h101;
    #1;
    total++;
    if (flush !== 1'b1) $display("FAIL jalr_flush: flush=%b expected 1", flush);
    else passed++;
    sb.push_back('{32'h100, 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if (pc !== e.pc || fetch_valid !== e.fv)
      $display("FAIL jalr_target: pc=%h fv=%b expected pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv);
    else passed++;
    ex_alu_c = 32'h102;
    #1;
    total++;
    if (flush !== 1'b0) $display("FAIL misalign_flush: flush=%b expected 0", flush);
    else passed++;
    sb.push_back('{32'h100, 1'b0});
    sb.push_back('{32'h100, 1'b0});
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 1) begin
        ex_npc_op = NPC_JAL; ex_pc = 32'h0; ex_imm = 32'h40;
      end
      #1;
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || fetch_valid !== e.fv || halted !== 1'b1 || flush !== 1'b0)
        $display("FAIL halt%0d: pc=%h fv=%b halted=%b flush=%b expected pc=%h fv=%b halted=1 flush=0",
                 i, pc, fetch_valid, halted, flush, e.pc, e.fv);
      else passed++;
    end
    ex_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jal();
    test_beq_stall();
    test_masked();
    test_branches();
    test_wrap();
    test_async_reset();
    test_perf();
    test_jalr_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
